// File: rtl/plot_writer.sv
// Queues pixel plots from an animation front end and writes them to frame memory,
// with a whole-frame fill (clear) that takes priority over queued pixels.
module plot_writer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  iX,
    input  logic [6:0]  iY,
    input  logic [8:0]  iColour,
    input  logic        iPlot,
    input  logic        iClear,
    input  logic [8:0]  iClearColour,
    input  logic        iMemReady,
    output logic [14:0] oAddr,
    output logic [8:0]  oData,
    output logic        oWren,
    output logic        oBusy,
    output logic        oOverflow,
    output logic [7:0]  oDropCount,
    output logic [1:0]  dbg_state
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [14:0]   W15   = 15'(SCREEN_W);
    localparam logic [14:0]   LAST  = 15'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state;

    logic [23:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          pending;
    logic [8:0]    pend_colour;

    logic          in_range;
    logic [14:0]   plot_addr;
    logic          push;
    logic          done;
    logic          pop;
    logic [23:0]   head;
    logic [23:0]   next_head;
    logic          clear_req;
    logic [8:0]    clear_colour;

    // Write handshake: oWren is valid, iMemReady is ready. oAddr/oData/oWren are
    // held unchanged until a cycle with both high, which is when the write completes.
    assign done = oWren & iMemReady;

    assign in_range  = (32'(iX) < SCREEN_W) && (32'(iY) < SCREEN_H);
    assign plot_addr = 15'(iY) * W15 + 15'(iX);
    assign push      = iPlot & in_range & (count != FULL);

    // The entry being written stays in the FIFO until its write completes, so the
    // in-flight pixel counts against FIFO capacity.
    assign pop       = (state == DRAIN) & done;
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + PW'(1)];

    assign clear_req    = pending | iClear;
    assign clear_colour = pending ? pend_colour : iClearColour;

    assign oBusy     = (state == CLEAR) | (count != '0) | oWren;
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {plot_addr, iColour};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            oOverflow  <= 1'b0;
            oDropCount <= '0;
        end else begin
            if (iPlot && in_range && count == FULL) begin
                oOverflow <= 1'b1;
            end
            if (iPlot && !in_range && oDropCount != 8'hFF) begin
                oDropCount <= oDropCount + 8'd1;
            end
        end
    end

    // During CLEAR the fill address and colour live directly in oAddr/oData.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            oWren       <= 1'b0;
            oAddr       <= '0;
            oData       <= '0;
            pending     <= 1'b0;
            pend_colour <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iClear) begin
                        state <= CLEAR;
                        oWren <= 1'b1;
                        oAddr <= '0;
                        oData <= iClearColour;
                    end else if (count != '0) begin
                        state          <= DRAIN;
                        oWren          <= 1'b1;
                        {oAddr, oData} <= head;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        if (clear_req) begin
                            state   <= CLEAR;
                            oAddr   <= '0;
                            oData   <= clear_colour;
                            pending <= 1'b0;
                        end else if (count > ONE) begin
                            {oAddr, oData} <= next_head;
                        end else begin
                            state <= IDLE;
                            oWren <= 1'b0;
                        end
                    end else if (iClear && !pending) begin
                        pending     <= 1'b1;
                        pend_colour <= iClearColour;
                    end
                end
                CLEAR: begin
                    if (done) begin
                        if (oAddr == LAST) begin
                            state <= IDLE;
                            oWren <= 1'b0;
                        end else begin
                            oAddr <= oAddr + 15'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    oWren <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_writer.sv
// Self-checking bench for plot_writer: a queue-based model of the expected write stream
// plus directed scenarios and randomized plotting with a stalling memory.
module tb_plot_writer;

    localparam int DEPTH = 8;
    localparam int SW    = 160;
    localparam int SH    = 120;
    localparam int NPIX  = SW * SH;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  plot_x = '0;
    logic [6:0]  plot_y = '0;
    logic [8:0]  plot_col = '0;
    logic        plot = 1'b0;
    logic        clear = 1'b0;
    logic [8:0]  clear_col = '0;
    logic        mem_ready = 1'b0;

    logic [14:0] oAddr;
    logic [8:0]  oData;
    logic        oWren;
    logic        oBusy;
    logic        oOverflow;
    logic [7:0]  oDropCount;
    logic [1:0]  dbg_state;

    plot_writer #(.DEPTH(DEPTH), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clock(clock), .resetn(resetn),
        .iX(plot_x), .iY(plot_y), .iColour(plot_col), .iPlot(plot),
        .iClear(clear), .iClearColour(clear_col), .iMemReady(mem_ready),
        .oAddr(oAddr), .oData(oData), .oWren(oWren), .oBusy(oBusy),
        .oOverflow(oOverflow), .oDropCount(oDropCount), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: expected writes in order; bit 24 marks a fill entry.
    logic [24:0] exp_q[$];
    int          m_occ = 0;
    int          m_clr_out = 0;
    int          m_drop = 0;
    logic        m_ovf = 1'b0;
    int          wr_count = 0;
    logic [14:0] last_addr = '0;
    logic [14:0] prev_done = '0;
    logic        stall_prev = 1'b0;
    logic [14:0] stall_addr = '0;
    logic [8:0]  stall_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compare process: at each falling edge, check outputs against the model, then
    // advance the model by what the coming rising edge will do.
    always @(negedge clock) begin
        int          old_occ;
        logic [24:0] e;
        if (!resetn) begin
            exp_q.delete();
            m_occ      = 0;
            m_clr_out  = 0;
            m_drop     = 0;
            m_ovf      = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("drop_count", 32'(oDropCount), 32'(m_drop));
            check("overflow", 32'(oOverflow), 32'(m_ovf));
            if (stall_prev) begin
                check("stall_hold", 32'({oWren, oAddr, oData}), 32'({1'b1, stall_addr, stall_data}));
            end
            if (clear && m_clr_out == 0) begin
                if (exp_q.size() == 0) begin
                    for (int i = 0; i < NPIX; i++) exp_q.push_back({1'b1, 15'(i), clear_col});
                end else begin
                    for (int i = 0; i < NPIX; i++) exp_q.insert(i + 1, {1'b1, 15'(i), clear_col});
                end
                m_clr_out = NPIX;
            end
            old_occ = m_occ;
            if (oWren && mem_ready) begin
                wr_count++;
                prev_done = last_addr;
                last_addr = oAddr;
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_data", 32'({oAddr, oData}), 32'(e[23:0]));
                    if (e[24]) m_clr_out--;
                    else m_occ--;
                end
            end
            if (plot) begin
                if (int'(plot_x) < SW && int'(plot_y) < SH) begin
                    if (old_occ == DEPTH) begin
                        m_ovf = 1'b1;
                    end else begin
                        exp_q.push_back({1'b0, 15'(int'(plot_y) * SW + int'(plot_x)), plot_col});
                        m_occ++;
                    end
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            stall_prev = oWren && !mem_ready;
            stall_addr = oAddr;
            stall_data = oData;
        end
    end

    task automatic wait_drained(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_within_budget", 32'(n < budget), 32'd1);
        tick();
        tick();
        check("idle_busy", 32'(oBusy), 32'd0);
        check("idle_wren", 32'(oWren), 32'd0);
    endtask

    task automatic do_plot(input int xv, input int yv, input logic [8:0] c);
        plot     = 1'b1;
        plot_x   = 8'(xv);
        plot_y   = 7'(yv);
        plot_col = c;
        tick();
        plot     = 1'b0;
    endtask

    initial begin
        int base;
        int n;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_wren", 32'(oWren), 32'd0);
        check("rst_addr", 32'(oAddr), 32'd0);
        check("rst_data", 32'(oData), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_ovf", 32'(oOverflow), 32'd0);
        check("rst_drop", 32'(oDropCount), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        resetn    = 1'b1;
        mem_ready = 1'b1;
        tick();

        // Single pixel latency
        do_plot(5, 2, 9'h1FF);
        check("lat_cycle1_wren", 32'(oWren), 32'd0);
        tick();
        check("lat_cycle2_wren", 32'(oWren), 32'd1);
        check("lat_cycle2_addr", 32'(oAddr), 32'd325);
        check("lat_cycle2_data", 32'(oData), 32'h1FF);
        tick();
        check("lat_cycle3_wren", 32'(oWren), 32'd0);
        check("lat_cycle3_busy", 32'(oBusy), 32'd0);

        // Corner pixel and out-of-range drops
        do_plot(159, 119, 9'h007);
        tick();
        check("corner_wren", 32'(oWren), 32'd1);
        check("corner_addr", 32'(oAddr), 32'd19199);
        wait_drained(20);
        base = wr_count;
        do_plot(160, 0, 9'h055);
        do_plot(0, 120, 9'h0AA);
        repeat (4) tick();
        check("oob_no_writes", 32'(wr_count - base), 32'd0);
        check("oob_drop_count", 32'(oDropCount), 32'd2);

        // Overflow with a stalled memory
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) do_plot(i, 0, 9'($urandom_range(0, 511)));
        repeat (2) tick();
        check("ovf_flag", 32'(oOverflow), 32'd1);
        check("ovf_hold_wren", 32'(oWren), 32'd1);
        check("ovf_hold_addr", 32'(oAddr), 32'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_burst_wren", 32'(oWren), 32'd1);
            check("ovf_burst_addr", 32'(oAddr), 32'(i));
            tick();
        end
        check("ovf_burst_end", 32'(oWren), 32'd0);

        // Ready toggling every cycle during a 4-pixel drain
        mem_ready = 1'b0;
        base = wr_count;
        for (int i = 0; i < 4; i++) do_plot($urandom_range(0, 159), $urandom_range(0, 119), 9'($urandom_range(0, 511)));
        for (int k = 0; k < 16; k++) begin
            mem_ready = (k % 2 == 0);
            tick();
        end
        mem_ready = 1'b1;
        wait_drained(20);
        check("toggle_write_count", 32'(wr_count - base), 32'd4);

        // Clear requested while a write is stalled mid-drain
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_plot($urandom_range(0, 159), $urandom_range(0, 119), 9'($urandom_range(0, 511)));
        repeat (3) tick();
        clear     = 1'b1;
        clear_col = 9'($urandom_range(0, 511));
        tick();
        clear     = 1'b0;
        repeat (2) tick();
        mem_ready = 1'b1;
        wait_drained(NPIX + 100);

        // Full clear with a plot issued mid-fill
        clear     = 1'b1;
        clear_col = 9'h0A0;
        tick();
        clear = 1'b0;
        check("clear_first_wren", 32'(oWren), 32'd1);
        check("clear_first_addr", 32'(oAddr), 32'd0);
        check("clear_first_data", 32'(oData), 32'h0A0);
        repeat (100) tick();
        do_plot(1, 0, 9'h1C3);
        wait_drained(NPIX + 100);
        check("clear_plot_last", 32'(last_addr), 32'd1);
        check("clear_fill_end", 32'(prev_done), 32'd19199);

        // Reset in the middle of a clear
        clear     = 1'b1;
        clear_col = 9'($urandom_range(0, 511));
        tick();
        clear = 1'b0;
        n = 0;
        while (oAddr != 15'd5000 && n < 6000) begin
            tick();
            n++;
        end
        check("reach_addr_5000", 32'(n < 6000), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("async_rst_wren", 32'(oWren), 32'd0);
        check("async_rst_busy", 32'(oBusy), 32'd0);
        check("async_rst_addr", 32'(oAddr), 32'd0);
        tick();
        resetn = 1'b1;
        base = wr_count;
        repeat (30) tick();
        check("post_rst_no_writes", 32'(wr_count - base), 32'd0);
        check("post_rst_wren", 32'(oWren), 32'd0);

        // Randomized plotting against a randomly stalling memory
        for (int k = 0; k < 600; k++) begin
            mem_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) != 0) begin
                plot     = 1'b1;
                plot_x   = 8'($urandom_range(0, 175));
                plot_y   = 7'($urandom_range(0, 127));
                plot_col = 9'($urandom_range(0, 511));
            end else begin
                plot = 1'b0;
            end
            tick();
        end
        plot      = 1'b0;
        mem_ready = 1'b1;
        wait_drained(200);

        // Drop counter saturation
        for (int k = 0; k < 300; k++) do_plot(200, 0, 9'h000);
        tick();
        check("drop_saturated", 32'(oDropCount), 32'd255);

        check("model_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
